// File: rtl/uio_arb_pkg.sv
// Shared types and defaults for the uio pad-bus arbiter.
//   state_t : arbiter FSM states
//   BUS_W   : width of the uio pad bus
//   *_DEF   : default parameter values for the arbiter and its interface
package uio_arb_pkg;

    localparam int unsigned BUS_W           = 8;
    localparam int unsigned NREQ_DEF        = 4;
    localparam int unsigned MAX_BURST_DEF   = 8;
    localparam int unsigned TURN_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side and pad-side signals of the uio bus arbiter.
//   req/dir/wdata : per-requester request, direction (1 = drive) and write data
//   gnt           : one-hot grant
//   uio_in/out/oe : pad bus
//   rdata/rvalid  : captured pad data for a read-mode owner
// master = requesters + pads (drives inputs), slave = arbiter.
interface uio_bus_arbiter_if
    import uio_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [NREQ*BUS_W-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [BUS_W-1:0]      uio_in;
    logic [BUS_W-1:0]      uio_out;
    logic [BUS_W-1:0]      uio_oe;
    logic [BUS_W-1:0]      rdata;
    logic                  rvalid;

    modport master (
        output req, dir, wdata, uio_in,
        input  gnt, uio_out, uio_oe, rdata, rvalid
    );

    modport slave (
        input  req, dir, wdata, uio_in,
        output gnt, uio_out, uio_oe, rdata, rvalid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req : request vector
//   ptr : highest-priority index; scan runs ptr, ptr+1, ... mod NREQ
//   any : at least one request set
//   idx : index of the first set request in scan order (0 when none)
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int unsigned k;

    // First set request at or after ptr, wrapping
    always_comb begin
        any = 1'b0;
        idx = '0;
        k   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!any && req[IDX_W'(k)]) begin
                any = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit bidirectional uio pad bus.
// Inserts TURN_CYCLES of undriven bus before every new owner or direction.
//   clk, rst_n : clock, async active-low reset
//   ena        : low = synchronous clear to IDLE (round-robin pointer kept)
//   bus        : requester/pad signals (slave modport); all outputs registered
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned NREQ        = NREQ_DEF,
    parameter int unsigned MAX_BURST   = MAX_BURST_DEF,
    parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    uio_bus_arbiter_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(NREQ);
    localparam int unsigned BURST_W = 8;
    localparam int unsigned TCNT_W  = 2;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [BUS_W-1:0]     out_q, out_d;
    logic [BUS_W-1:0]     oe_q, oe_d;
    logic [BUS_W-1:0]     rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 odir_q, odir_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;

    logic                 idle_any;
    logic [IDX_W-1:0]     idle_idx;
    logic [NREQ-1:0]      others;
    logic                 rel_any;
    logic [IDX_W-1:0]     rel_idx;
    logic [IDX_W-1:0]     owner_nxt;
    logic                 owner_req;
    logic                 owner_dir;
    logic [BUS_W-1:0]     owner_wdata;
    logic                 burst_at_max;

    // Fresh arbitration from IDLE, scanning from ptr
    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_idle (
        .req (bus.req),
        .ptr (ptr_q),
        .any (idle_any),
        .idx (idle_idx)
    );

    // Arbitration on release: owner excluded, scanning from the updated ptr
    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_rel (
        .req (others),
        .ptr (owner_nxt),
        .any (rel_any),
        .idx (rel_idx)
    );

    assign others       = bus.req & ~(NREQ'(1) << owner_q);
    assign owner_nxt    = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + IDX_W'(1);
    assign owner_req    = bus.req[owner_q];
    assign owner_dir    = bus.dir[owner_q];
    assign owner_wdata  = bus.wdata[32'(owner_q) * BUS_W +: BUS_W];
    assign burst_at_max = (burst_q == BURST_W'(MAX_BURST));

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        out_d    = out_q;
        oe_d     = oe_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        odir_d   = odir_q;
        burst_d  = burst_q;
        tcnt_d   = tcnt_q;

        if (!ena) begin
            state_d = IDLE;
            gnt_d   = '0;
            out_d   = '0;
            oe_d    = '0;
            rdata_d = '0;
            owner_d = '0;
            odir_d  = 1'b0;
            burst_d = '0;
            tcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    gnt_d = '0;
                    oe_d  = '0;
                    if (idle_any) begin
                        owner_d = idle_idx;
                        odir_d  = bus.dir[idle_idx];
                        tcnt_d  = TCNT_W'(TURN_CYCLES - 1);
                        state_d = TURN;
                    end
                end

                TURN: begin
                    oe_d = '0;
                    if (tcnt_q != '0) begin
                        tcnt_d = tcnt_q - TCNT_W'(1);
                    end else if (owner_req) begin
                        state_d = OWN;
                        gnt_d   = NREQ'(1) << owner_q;
                        oe_d    = {BUS_W{odir_q}};
                        out_d   = owner_wdata;
                        // A held grant marks a direction-change turn: keep burst
                        if (gnt_q == '0) begin
                            burst_d = BURST_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end

                OWN: begin
                    if (!owner_req || (burst_at_max && rel_any)) begin
                        gnt_d = '0;
                        oe_d  = '0;
                        ptr_d = owner_nxt;
                        if (rel_any) begin
                            owner_d = rel_idx;
                            odir_d  = bus.dir[rel_idx];
                            tcnt_d  = TCNT_W'(TURN_CYCLES - 1);
                            state_d = TURN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (owner_dir != odir_q) begin
                        state_d = TURN;
                        oe_d    = '0;
                        odir_d  = owner_dir;
                        tcnt_d  = TCNT_W'(TURN_CYCLES - 1);
                    end else begin
                        out_d = owner_wdata;
                        if (!odir_q) begin
                            rdata_d  = bus.uio_in;
                            rvalid_d = 1'b1;
                        end
                        if (!burst_at_max) begin
                            burst_d = burst_q + BURST_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    oe_d    = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ptr_q    <= '0;
            owner_q  <= '0;
            odir_q   <= 1'b0;
            burst_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            odir_q   <= odir_d;
            burst_q  <= burst_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.uio_out = out_q;
    assign bus.uio_oe  = oe_q;
    assign bus.rdata   = rdata_q;
    assign bus.rvalid  = rvalid_q;

    // Bus-safety invariants
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_oe_levels: assert property (@(posedge clk) disable iff (!rst_n)
        (oe_q == '0) || (oe_q == '1));
    a_oe_own: assert property (@(posedge clk) disable iff (!rst_n)
        (oe_q != '0) |-> (state_q == OWN));
    a_oe_turn: assert property (@(posedge clk) disable iff (!rst_n)
        ((oe_q != '0) && ($past(oe_q) != '0)) |-> (owner_q == $past(owner_q)));

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter (NREQ=4, MAX_BURST=4, TURN_CYCLES=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uio_bus_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int TC = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    uio_bus_arbiter_if #(.NREQ(NR)) bus ();

    uio_bus_arbiter #(.NREQ(NR), .MAX_BURST(MB), .TURN_CYCLES(TC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state (behavioural, one step per clock edge)
    int       m_ptr, m_owner, m_wait, m_burst;
    bit       m_own, m_odir, m_hold;
    logic [3:0] e_gnt;
    logic [7:0] e_out, e_oe, e_rdata;
    logic       e_rvalid;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int off = 0; off < NR; off++) begin
            if (r[(from + off) % NR]) return (from + off) % NR;
        end
        return -1;
    endfunction

    task automatic model_clear(input bit keep_ptr);
        if (!keep_ptr) m_ptr = 0;
        m_owner = 0; m_wait = 0; m_burst = 0;
        m_own = 0; m_odir = 0; m_hold = 0;
        e_gnt = '0; e_out = '0; e_oe = '0; e_rdata = '0; e_rvalid = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] others;
        int w;
        if (!ena) begin
            model_clear(1'b1);
            return;
        end
        e_rvalid = 1'b0;
        if (m_own) begin
            others = bus.req & ~(4'b0001 << m_owner);
            if (!bus.req[m_owner] || (m_burst == MB && others != 0)) begin
                e_gnt = '0; e_oe = '0; m_own = 0;
                m_ptr = (m_owner + 1) % NR;
                w = pick(others, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_odir = bus.dir[w]; m_wait = TC; m_hold = 0;
                end
            end else if (bus.dir[m_owner] != m_odir) begin
                m_own = 0; m_odir = bus.dir[m_owner]; m_wait = TC; m_hold = 1; e_oe = '0;
            end else begin
                e_out = bus.wdata[8*m_owner +: 8];
                if (!m_odir) begin
                    e_rdata = bus.uio_in; e_rvalid = 1'b1;
                end
                if (m_burst < MB) m_burst++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                if (bus.req[m_owner]) begin
                    m_own = 1; e_gnt = 4'b0001 << m_owner;
                    if (!m_hold) m_burst = 1;
                    e_oe = {8{m_odir}}; e_out = bus.wdata[8*m_owner +: 8];
                end else begin
                    e_gnt = '0; m_hold = 0;
                end
            end
        end else begin
            w = pick(bus.req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_odir = bus.dir[w]; m_wait = TC; m_hold = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.req = '0; bus.dir = '0; bus.wdata = '0; bus.uio_in = '0; ena = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.uio_out, bus.rdata, bus.rvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b oe=%h out=%h rdata=%h rvalid=%b, required all zero",
                     bus.gnt, bus.uio_oe, bus.uio_out, bus.rdata, bus.rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata[7:0] = 8'hC6;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.uio_out} !== {4'b0001, 8'hFF, 8'hC6}) begin
            n_fail++;
            $display("FAIL reset_pre_own: gnt=%b oe=%h out=%h, required 0001 ff c6",
                     bus.gnt, bus.uio_oe, bus.uio_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.uio_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: gnt=%b oe=%h out=%h, required all zero",
                     bus.gnt, bus.uio_oe, bus.uio_out);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata[7:0] = 8'hA5;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe} !== {4'b0000, 8'h00}) begin
            n_fail++;
            $display("FAIL write_turn: gnt=%b oe=%h, required 0000 00", bus.gnt, bus.uio_oe);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.uio_out} !== {4'b0001, 8'hFF, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_own: gnt=%b oe=%h out=%h, required 0001 ff a5",
                     bus.gnt, bus.uio_oe, bus.uio_out);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe} !== {4'b0000, 8'h00}) begin
            n_fail++;
            $display("FAIL write_release: gnt=%b oe=%h, required 0000 00", bus.gnt, bus.uio_oe);
        end
    endtask

    task automatic test_read();
        do_reset();
        bus.req = 4'b0010; bus.dir = 4'b0000; bus.uio_in = 8'h3C;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.rvalid} !== {4'b0010, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL read_own: gnt=%b oe=%h rvalid=%b, required 0010 00 0",
                     bus.gnt, bus.uio_oe, bus.rvalid);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.rdata, bus.rvalid, bus.uio_oe} !== {8'h3C, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL read_data: rdata=%h rvalid=%b oe=%h, required 3c 1 00",
                     bus.rdata, bus.rvalid, bus.uio_oe);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.rvalid} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL read_release: gnt=%b rvalid=%b, required 0000 0", bus.gnt, bus.rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        bus.req = 4'b0101; bus.dir = 4'b0101; bus.wdata = 32'h44332211;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1 || k == 6 || k == 11) exp = 4'b0000;
            else if (k < 6 || k > 11)        exp = 4'b0001;
            else                             exp = 4'b0100;
            n_checks++;
            if (bus.gnt !== exp) begin
                n_fail++;
                $display("FAIL rr_gnt cycle %0d: gnt=%b, required %b", k, bus.gnt, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_dir_flip();
        do_reset();
        bus.req = 4'b1000; bus.dir = 4'b1000; bus.wdata[31:24] = 8'h5A;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe} !== {4'b1000, 8'hFF}) begin
            n_fail++;
            $display("FAIL flip_own: gnt=%b oe=%h, required 1000 ff", bus.gnt, bus.uio_oe);
        end
        bus.dir = 4'b0000; bus.uio_in = 8'hC3;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.rvalid} !== {4'b1000, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL flip_turn: gnt=%b oe=%h rvalid=%b, required 1000 00 0",
                     bus.gnt, bus.uio_oe, bus.rvalid);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL flip_back: gnt=%b oe=%h, required 1000 00", bus.gnt, bus.uio_oe);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 8'hC3}) begin
            n_fail++;
            $display("FAIL flip_rvalid: rvalid=%b rdata=%h, required 1 c3", bus.rvalid, bus.rdata);
        end
        idle_inputs();
    endtask

    task automatic test_abandon_enable();
        do_reset();
        bus.req = 4'b0010; bus.dir = 4'b0010;
        @(negedge clk);
        bus.req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({bus.gnt, bus.uio_oe} !== '0) begin
                n_fail++;
                $display("FAIL abandon: gnt=%b oe=%h, required 0000 00", bus.gnt, bus.uio_oe);
            end
        end
        // Owner 2 releases normally, leaving ptr at 3
        bus.req = 4'b0100; bus.dir = 4'b0100; bus.wdata[23:16] = 8'h77;
        repeat (2) @(negedge clk);
        bus.req = 4'b0000;
        @(negedge clk);
        // Owner 0 is cleared by ena=0 without releasing, so ptr stays 3
        bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata[7:0] = 8'h99;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL ena_pre: gnt=%b, required 0001", bus.gnt);
        end
        ena = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.uio_oe, bus.uio_out} !== '0) begin
            n_fail++;
            $display("FAIL ena_clear: gnt=%b oe=%h out=%h, required all zero",
                     bus.gnt, bus.uio_oe, bus.uio_out);
        end
        ena = 1'b1;
        bus.req = 4'b1001; bus.dir = 4'b1001;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL ena_ptr_kept: gnt=%b, required 1000", bus.gnt);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        model_clear(1'b0);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
                if ($urandom_range(0, 9) == 0) bus.dir[i] = ~bus.dir[i];
            end
            bus.wdata  = $urandom;
            bus.uio_in = 8'($urandom);
            ena        = ($urandom_range(0, 39) != 0);
            @(negedge clk);
            model_step();
            n_checks++;
            if ({bus.gnt, bus.uio_oe, bus.uio_out, bus.rvalid} !== {e_gnt, e_oe, e_out, e_rvalid}) begin
                n_fail++;
                $display("FAIL rand_bus cycle %0d: gnt=%b oe=%h out=%h rvalid=%b, required %b %h %h %b",
                         c, bus.gnt, bus.uio_oe, bus.uio_out, bus.rvalid, e_gnt, e_oe, e_out, e_rvalid);
            end
            n_checks++;
            if (bus.rdata !== e_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata cycle %0d: rdata=%h, required %h", c, bus.rdata, e_rdata);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_dir_flip();
        test_abandon_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
